// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the APB requester bridge: bus widths, FSM
// encoding and the round-robin pointer wrap helper.
package apb_bridge_pkg;

    localparam int APB_ADDR_W = 7;
    localparam int APB_DATA_W = 8;
    localparam int GID_W      = 3;   // requester index width, enough for 8 requesters

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Index of the requester after id, wrapping at n.
    function automatic logic [GID_W-1:0] wrap_inc(input logic [GID_W-1:0] id, input int n);
        return (int'(id) == n - 1) ? '0 : id + GID_W'(1);
    endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester-side and master-side signal bundle of the APB requester bridge.
// The slave modport is the bridge's view; the master modport is the view of
// whatever surrounds it (requesters plus apb_master).
interface apb_req_arbiter_if #(parameter int NUM_REQ = 4) ();
    import apb_bridge_pkg::*;

    // requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*APB_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*APB_DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]            rsp_done;
    logic                          rsp_err;
    logic [APB_DATA_W-1:0]         rsp_rdata;
    logic                          busy;
    logic [GID_W-1:0]              grant_id;

    // apb_master side
    logic                          m_enable;
    logic                          m_write;
    logic                          m_read;
    logic                          m_data_send;
    logic [APB_ADDR_W-1:0]         m_addr;
    logic [APB_DATA_W-1:0]         m_wdata;
    logic                          m_ready;
    logic [APB_DATA_W-1:0]         m_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, m_ready, m_rdata,
        output rsp_done, rsp_err, rsp_rdata, busy, grant_id,
               m_enable, m_write, m_read, m_data_send, m_addr, m_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, m_ready, m_rdata,
        input  rsp_done, rsp_err, rsp_rdata, busy, grant_id,
               m_enable, m_write, m_read, m_data_send, m_addr, m_wdata
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo NUM_REQ. Returns one-hot grant and its binary index.
module rr_arbiter
    import apb_bridge_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [GID_W-1:0]   grant_id,
    output logic               any
);

    logic found;

    // Scan offsets 0..NUM_REQ-1 from ptr; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop, so no path leaves a value held and no latch is inferred.
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (j == (int'(ptr) + off) % NUM_REQ)) begin
                    found    = 1'b1;
                    grant[j] = 1'b1;
                    grant_id = GID_W'(j);
                end
            end
        end
        any = |req;
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares the single apb_master command port between NUM_REQ requesters.
// One command is latched in IDLE, pulsed for one cycle in ISSUE, then the
// bridge sits in WAIT with all strobes low until m_ready or a timeout, and
// reports back to the granted requester in RESP. All outputs are registered.
module apb_req_arbiter
    import apb_bridge_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    apb_req_arbiter_if.slave bus
);

    // Registered output image, next-value computed combinationally.
    typedef struct packed {
        logic [NUM_REQ-1:0]    rsp_done;
        logic                  rsp_err;
        logic [APB_DATA_W-1:0] rsp_rdata;
        logic                  busy;
        logic                  m_enable;
        logic                  m_write;
        logic                  m_read;
        logic                  m_data_send;
        logic [APB_ADDR_W-1:0] m_addr;
        logic [APB_DATA_W-1:0] m_wdata;
    } out_t;

    state_t              state_q, state_d;
    out_t                out_q, out_d;
    logic [GID_W-1:0]    ptr_q, ptr_d;
    logic [GID_W-1:0]    grant_id_q, grant_id_d;
    logic [NUM_REQ-1:0]  grant_oh_q, grant_oh_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                lat_write_q, lat_write_d;

    logic [NUM_REQ-1:0]    arb_grant;
    logic [GID_W-1:0]      arb_id;
    logic                  arb_any;
    logic                  sel_write;
    logic [APB_ADDR_W-1:0] sel_addr;
    logic [APB_DATA_W-1:0] sel_wdata;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (bus.req_valid),
        .ptr      (ptr_q),
        .grant    (arb_grant),
        .grant_id (arb_id),
        .any      (arb_any)
    );

    // Mux the winning requester's command fields out of the packed buses.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_write = bus.req_write[i];
                sel_addr  = bus.req_addr[i*APB_ADDR_W +: APB_ADDR_W];
                sel_wdata = bus.req_wdata[i*APB_DATA_W +: APB_DATA_W];
            end
        end
    end

    // Next state and next registered outputs; strobes and rsp_done default low.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        grant_id_d  = grant_id_q;
        grant_oh_d  = grant_oh_q;
        lat_write_d = lat_write_q;
        out_d             = out_q;
        out_d.rsp_done    = '0;
        out_d.m_enable    = 1'b0;
        out_d.m_write     = 1'b0;
        out_d.m_read      = 1'b0;
        out_d.m_data_send = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d           = ISSUE;
                    grant_id_d        = arb_id;
                    grant_oh_d        = arb_grant;
                    lat_write_d       = sel_write;
                    out_d.m_enable    = 1'b1;
                    out_d.m_write     = sel_write;
                    out_d.m_read      = !sel_write;
                    out_d.m_data_send = sel_write;
                    out_d.m_addr      = sel_addr;
                    out_d.m_wdata     = sel_write ? sel_wdata : '0;
                end
            end
            ISSUE: begin
                // m_ready here belongs to no command of ours and is ignored.
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.m_ready) begin
                    out_d.rsp_rdata = lat_write_q ? '0 : bus.m_rdata;
                    out_d.rsp_err   = 1'b0;
                    out_d.rsp_done  = grant_oh_q;
                    state_d         = RESP;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    out_d.rsp_rdata = '0;
                    out_d.rsp_err   = 1'b1;
                    out_d.rsp_done  = grant_oh_q;
                    state_d         = RESP;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            RESP: begin
                ptr_d   = wrap_inc(grant_id_q, NUM_REQ);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        out_d.busy = (state_d != IDLE);
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            grant_oh_q  <= '0;
            cnt_q       <= '0;
            lat_write_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            out_q       <= out_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            grant_oh_q  <= grant_oh_d;
            cnt_q       <= cnt_d;
            lat_write_q <= lat_write_d;
        end
    end

    assign bus.rsp_done    = out_q.rsp_done;
    assign bus.rsp_err     = out_q.rsp_err;
    assign bus.rsp_rdata   = out_q.rsp_rdata;
    assign bus.busy        = out_q.busy;
    assign bus.grant_id    = grant_id_q;
    assign bus.m_enable    = out_q.m_enable;
    assign bus.m_write     = out_q.m_write;
    assign bus.m_read      = out_q.m_read;
    assign bus.m_data_send = out_q.m_data_send;
    assign bus.m_addr      = out_q.m_addr;
    assign bus.m_wdata     = out_q.m_wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: table of single transactions, round-robin
// sequence from reset, and reset dropped in the middle of WAIT. Responses
// are checked against a queue of expected results filled at issue time.
module tb_apb_req_arbiter;
    import apb_bridge_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 255;
    localparam int AW_ALL  = NUM_REQ * APB_ADDR_W;
    localparam int DW_ALL  = NUM_REQ * APB_DATA_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apb_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_if ();

    apb_req_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [NUM_REQ-1:0] done;
        logic               err;
        logic [7:0]         rdata;
        bit                 chk_rdata;
    } rsp_t;

    rsp_t sb[$];

    // One transaction record: stimulus columns, then expected-result columns.
    typedef struct {
        int         id;
        bit         wr;
        logic [6:0] addr;
        logic [7:0] wdata;
        int         dly;       // negedges after ISSUE before m_ready; -1 = never
        logic [7:0] rdata;
        logic [7:0] exp_rdata;
        bit         exp_err;
        int         exp_lat;   // negedges from ISSUE to rsp_done
    } vec_t;

    vec_t vecs[6];

    // Scoreboard: every rsp_done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus_if.rsp_done != '0) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'(bus_if.rsp_done), 64'd0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_done", 64'(bus_if.rsp_done), 64'(e.done));
                check("rsp_err", 64'(bus_if.rsp_err), 64'(e.err));
                if (e.chk_rdata) check("rsp_rdata", 64'(bus_if.rsp_rdata), 64'(e.rdata));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] all_outputs();
        return 64'({bus_if.rsp_done, bus_if.rsp_err, bus_if.rsp_rdata, bus_if.busy,
                    bus_if.grant_id, bus_if.m_enable, bus_if.m_write, bus_if.m_read,
                    bus_if.m_data_send, bus_if.m_addr, bus_if.m_wdata});
    endfunction

    // Bounded wait for the ISSUE pulse.
    task automatic wait_enable(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_if.m_enable) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("m_enable_seen", 64'(bus_if.m_enable), 64'd1);
    endtask

    // Called at the ISSUE negedge: plays the master, returns negedges until rsp_done.
    task automatic respond(input int d, input logic [7:0] rdata, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        bus_if.m_ready = (d == 0);
        bus_if.m_rdata = (d == 0) ? rdata : 8'hEE;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1)
                check("strobes_after_issue",
                      64'({bus_if.m_enable, bus_if.m_write, bus_if.m_read, bus_if.m_data_send}), 64'd0);
            if (bus_if.rsp_done != '0) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
            bus_if.m_ready = (c == d);
            bus_if.m_rdata = (c == d) ? rdata : 8'hEE;
        end
        bus_if.m_ready = 1'b0;
        bus_if.m_rdata = 8'hEE;
        if (!seen) check("rsp_seen", 64'(seen), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        rsp_t e;
        int   lat;
        @(negedge clk);
        bus_if.req_valid = NUM_REQ'(1) << v.id;
        bus_if.req_write = NUM_REQ'(v.wr) << v.id;
        bus_if.req_addr  = AW_ALL'(v.addr) << (APB_ADDR_W * v.id);
        bus_if.req_wdata = DW_ALL'(v.wdata) << (APB_DATA_W * v.id);
        e.done      = NUM_REQ'(1) << v.id;
        e.err       = v.exp_err;
        e.rdata     = v.exp_rdata;
        e.chk_rdata = !v.wr || v.exp_err;
        sb.push_back(e);
        @(negedge clk);
        check("issue_m_enable", 64'(bus_if.m_enable), 64'd1);
        check("issue_m_write", 64'(bus_if.m_write), 64'(v.wr));
        check("issue_m_read", 64'(bus_if.m_read), 64'(!v.wr));
        check("issue_m_data_send", 64'(bus_if.m_data_send), 64'(v.wr));
        check("issue_m_addr", 64'(bus_if.m_addr), 64'(v.addr));
        if (v.wr) check("issue_m_wdata", 64'(bus_if.m_wdata), 64'(v.wdata));
        check("issue_grant_id", 64'(bus_if.grant_id), 64'(v.id));
        check("issue_busy", 64'(bus_if.busy), 64'd1);
        respond(v.dly, v.rdata, lat);
        check("rsp_latency", 64'(lat), 64'(v.exp_lat));
        bus_if.req_valid = '0;
        @(negedge clk);
        check("idle_after_resp", 64'({bus_if.busy, bus_if.rsp_done}), 64'd0);
    endtask

    initial begin
        bit   ok;
        int   lat;
        rsp_t e;

        //             id wr addr   wdata  dly   rdata  exp_rd err lat
        vecs[0] = '{2, 1'b1, 7'h15, 8'hA5, 3,    8'h00, 8'h00, 1'b0, 4};
        vecs[1] = '{0, 1'b0, 7'h03, 8'h00, 1,    8'h3C, 8'h3C, 1'b0, 2};
        vecs[2] = '{1, 1'b0, 7'h7F, 8'h00, 255,  8'hC3, 8'hC3, 1'b0, 256};
        vecs[3] = '{3, 1'b1, 7'h00, 8'hFF, 0,    8'h00, 8'h00, 1'b1, 256};
        vecs[4] = '{1, 1'b0, 7'h2A, 8'h00, -1,   8'h99, 8'h00, 1'b1, 256};
        vecs[5] = '{3, 1'b0, 7'h40, 8'h00, 254,  8'h81, 8'h81, 1'b0, 255};

        // All four requesters valid (reads) from reset.
        rst              = 1'b1;
        bus_if.req_valid = 4'hF;
        bus_if.req_write = '0;
        bus_if.req_addr  = {7'h33, 7'h22, 7'h11, 7'h05};
        bus_if.req_wdata = '0;
        bus_if.m_ready   = 1'b0;
        bus_if.m_rdata   = 8'hEE;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            logic [6:0] exp_addr [4];
            exp_addr = '{7'h05, 7'h11, 7'h22, 7'h33};
            wait_enable(ok);
            check("rr_grant_id", 64'(bus_if.grant_id), 64'(k % NUM_REQ));
            check("rr_m_addr", 64'(bus_if.m_addr), 64'(exp_addr[k % NUM_REQ]));
            e.done      = NUM_REQ'(1) << (k % NUM_REQ);
            e.err       = 1'b0;
            e.rdata     = 8'(8'h10 + k);
            e.chk_rdata = 1'b1;
            sb.push_back(e);
            respond(1, 8'(8'h10 + k), lat);
            check("rr_latency", 64'(lat), 64'd2);
            if (k == 4) bus_if.req_valid = '0;
        end
        @(negedge clk);
        check("rr_idle_busy", 64'(bus_if.busy), 64'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in WAIT with requester 3 still asking.
        @(negedge clk);
        bus_if.req_valid = 4'b1000;
        bus_if.req_write = '0;
        bus_if.req_addr  = AW_ALL'(7'h5D) << (APB_ADDR_W * 3);
        wait_enable(ok);
        check("pre_reset_grant", 64'(bus_if.grant_id), 64'd3);
        for (int c = 0; c < 3; c++) @(negedge clk);
        check("pre_reset_busy", 64'(bus_if.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("reset_in_wait_outputs", all_outputs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        e.done      = 4'b1000;
        e.err       = 1'b0;
        e.rdata     = 8'h77;
        e.chk_rdata = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        check("post_reset_m_enable", 64'(bus_if.m_enable), 64'd1);
        check("post_reset_grant", 64'(bus_if.grant_id), 64'd3);
        check("post_reset_m_addr", 64'(bus_if.m_addr), 64'h5D);
        respond(2, 8'h77, lat);
        check("post_reset_latency", 64'(lat), 64'd3);
        bus_if.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("final_busy", 64'(bus_if.busy), 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares the single APB master command port between NUM_REQ requesters (I2C slave, debug host, etc.) using round-robin arbitration.
- Latches one requester's command and pulses it into the master for exactly one cycle.
- Waits for the master's completion or a timeout, then returns read data and status to the granted requester.
- Sits between the requester side and apb_master; owns transaction sequencing so that the master never re-launches a command that is still being held.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 255, WAIT cycles without m_ready before the transaction is aborted with error.
- TO_W, 8, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  NUM_REQ  per-requester request; held until its rsp_done.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*7  packed addresses; requester i at bits [7i+6:7i].
- req_wdata  in  NUM_REQ*8  packed write data; requester i at bits [8i+7:8i].
- rsp_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_err  out  1  error status, valid with rsp_done.
- rsp_rdata  out  8  read data, valid with rsp_done on reads.
- busy  out  1  high in every state except IDLE.
- grant_id  out  3  index of the current or last granted requester.
- m_enable  out  1  to master apb_enable.
- m_write  out  1  to master apb_write.
- m_read  out  1  to master apb_read.
- m_data_send  out  1  to master data_send.
- m_addr  out  7  to master apb_addr.
- m_wdata  out  8  to master apb_wdata.
- m_ready  in  1  from master apb_master_ready.
- m_rdata  in  8  from master i2c_out.

Behaviour:
- Reset is asynchronous, active-high on rst; clock is clk.
- On reset:
  - State is IDLE.
  - All outputs are 0: rsp_done, rsp_err, rsp_rdata, busy, grant_id, and all m_* outputs.
  - Round-robin pointer is 0, so requester 0 has first priority.
  - Timeout counter is 0.
- Reset mid-transaction drops the transaction; no rsp_done is issued.
- All outputs are registered.
- States:
  - IDLE:
    - If any req_valid is set, pick the first set bit searching from ptr, ptr+1, … wrapping mod NUM_REQ.
    - Latch that requester's write, addr and wdata; set grant_id; go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - m_enable = 1 and m_addr = latched address.
    - Write: m_write = 1, m_data_send = 1, m_wdata = latched data. Read: m_read = 1.
    - Clear the timeout counter; go to WAIT.
  - WAIT:
    - All m_enable, m_write, m_read and m_data_send are 0, so the master cannot re-launch the command.
    - If m_ready = 1: capture m_rdata into rsp_rdata (reads only), set rsp_err = 0, go to RESP.
    - Else if counter == TIMEOUT-1: set rsp_err = 1, rsp_rdata = 0, go to RESP.
    - Else increment the counter.
  - RESP (1 cycle):
    - rsp_done[grant_id] = 1.
    - ptr = grant_id + 1 mod NUM_REQ.
    - Go to IDLE; rsp_done returns to 0.
- Handshake rules:
  - A requester must drop req_valid in the cycle after rsp_done unless it is presenting a new request.
  - Command fields are sampled only in IDLE; later changes to them are ignored.
  - Dropping req_valid after grant does not cancel the transaction; rsp_done still pulses.
  - A requester cannot be re-granted before another pending requester has been served (round-robin fairness).
- Timing:
  - Latency from req_valid high (in IDLE) to m_enable is 1 cycle.
  - rsp_done follows the m_ready sample by 1 cycle.
  - Minimum back-to-back turnaround is IDLE → ISSUE → WAIT → RESP → IDLE.
- Boundary conditions:
  - m_ready in ISSUE is ignored.
  - m_ready arriving in the same cycle the counter reaches TIMEOUT-1: m_ready wins, no error.
  - A master-side slave error gives no m_ready, so it resolves as a timeout with rsp_err = 1.

Decomposition:
- Shared package apb_bridge_pkg:
  - state encoding (IDLE, ISSUE, WAIT, RESP; 2 bits).
  - APB_ADDR_W = 7, APB_DATA_W = 8.
- One natural sub-module, rr_arbiter: combinational next-grant from the req vector and ptr, returning a one-hot grant plus a binary index.

Test Plan:
- Single write from req 2 (addr 7'h15, data 8'hA5), m_ready pulsed 3 cycles after ISSUE -> one cycle of m_enable with m_write = 1, m_data_send = 1, m_addr = 15, m_wdata = A5; then rsp_done = 4'b0100, rsp_err = 0.
- Read from req 0 (addr 7'h03), m_rdata = 8'h3C with m_ready -> rsp_rdata = 3C, rsp_done[0] = 1, m_read high for exactly 1 cycle.
- All 4 requesters valid continuously from reset -> grants in order 0, 1, 2, 3, 0; each rsp_done exactly once per grant.
- m_ready never asserted, TIMEOUT = 255 -> rsp_done with rsp_err = 1 exactly 255 cycles after entering WAIT; busy low afterwards.
- m_ready coincident with counter = TIMEOUT-1 -> rsp_err = 0, read data captured.
- rst asserted in WAIT -> all outputs 0 immediately; with req 3 still valid, next grant is to requester 3 (ptr reset to 0, none of requesters 0..2 valid).
